// File: rtl/dbg_pkg.sv
// Shared encodings for the debug run/step controller: FSM states and run modes.
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_e;

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_RUNN = 2'b10;

    // Mode 11 is not a distinct mode and behaves as a single step.
    function automatic logic mode_is_step(input logic [1:0] mode);
        return (mode != MODE_RUN) && (mode != MODE_RUNN);
    endfunction

endpackage

// File: rtl/debug_run_controller_if.sv
// Debug control/status bundle between the processor debug top and the run controller.
interface debug_run_controller_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 16
) ();
    logic              stepPulse;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  runCount;
    logic [ADDR_W-1:0] pcAddr;
    logic              bpWrite;
    logic [IDX_W-1:0]  bpIndex;
    logic [ADDR_W-1:0] bpAddr;
    logic              bpClear;
    logic              cntClear;
    logic              stepEnable;
    logic              running;
    logic              hitValid;
    logic [IDX_W-1:0]  hitIndex;
    logic [CNT_W-1:0]  instrCount;

    modport master (
        output stepPulse, mode, runCount, pcAddr, bpWrite, bpIndex, bpAddr, bpClear, cntClear,
        input  stepEnable, running, hitValid, hitIndex, instrCount
    );

    modport slave (
        input  stepPulse, mode, runCount, pcAddr, bpWrite, bpIndex, bpAddr, bpClear, cntClear,
        output stepEnable, running, hitValid, hitIndex, instrCount
    );
endinterface

// File: rtl/bp_match_bank.sv
// PC breakpoint table: registered address/valid entries and a lowest-index-wins comparator.
module bp_match_bank #(
    parameter int NUM_BP = 4,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              match_o,
    output logic [IDX_W-1:0]  match_index_o
);

    logic [ADDR_W-1:0] addr_q [NUM_BP];
    logic [ADDR_W-1:0] addr_d [NUM_BP];
    logic [NUM_BP-1:0] valid_q;
    logic [NUM_BP-1:0] valid_d;
    logic [NUM_BP-1:0] hit_s;

    // Table update: a clear drops any write issued in the same cycle.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clr_i) begin
            valid_d = '0;
        end else if (wr_i && (int'(idx_i) < NUM_BP)) begin
            valid_d[idx_i] = 1'b1;
            addr_d[idx_i]  = addr_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Table registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    // Priority compare; scanning downward leaves the lowest hitting index.
    always_comb begin
        match_o       = 1'b0;
        match_index_o = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            hit_s[i]      = valid_q[i] && (addr_q[i] == pc_i);
            match_o       = match_o | hit_s[i];
            match_index_o = hit_s[i] ? IDX_W'(i) : match_index_o;
        end
    end

endmodule

// File: rtl/debug_run_controller.sv
// Run/step controller: gates processor advance for single step, run-to-breakpoint and run-N.
module debug_run_controller
    import dbg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    debug_run_controller_if.slave  dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic             run_n_q, run_n_d;
    logic             skip_q, skip_d;
    logic [IDX_W-1:0] hit_index_q, hit_index_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             step_en_s;
    logic             match_s;
    logic [IDX_W-1:0] match_index_s;

    bp_match_bank #(
        .NUM_BP (NUM_BP),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk_i         (Clk),
        .rst_ni        (Rst),
        .wr_i          (dbg.bpWrite),
        .idx_i         (dbg.bpIndex),
        .addr_i        (dbg.bpAddr),
        .clr_i         (dbg.bpClear),
        .pc_i          (dbg.pcAddr),
        .match_o       (match_s),
        .match_index_o (match_index_s)
    );

    // Next-state and advance-enable decode.
    always_comb begin
        state_d     = state_q;
        budget_d    = budget_q;
        run_n_d     = run_n_q;
        skip_d      = skip_q;
        hit_index_d = hit_index_q;
        step_en_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_BREAK: begin
                if (dbg.stepPulse) begin
                    skip_d = (state_q == ST_BREAK);
                    if (mode_is_step(dbg.mode)) begin
                        state_d = ST_STEP;
                    end else if (dbg.mode == MODE_RUN) begin
                        state_d  = ST_RUN;
                        run_n_d  = 1'b0;
                        budget_d = '0;
                    end else if ((state_q == ST_BREAK) && (budget_q != '0)) begin
                        // Resuming a halted run-N continues its remaining budget.
                        state_d = ST_RUN;
                        run_n_d = 1'b1;
                    end else if (dbg.runCount != '0) begin
                        state_d  = ST_RUN;
                        run_n_d  = 1'b1;
                        budget_d = dbg.runCount;
                    end else begin
                        state_d = ST_IDLE;
                        skip_d  = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_STEP: begin
                step_en_s = 1'b1;
                skip_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_RUN: begin
                if (dbg.stepPulse) begin
                    state_d = ST_IDLE;
                end else if (match_s && !skip_q) begin
                    state_d     = ST_BREAK;
                    hit_index_d = match_index_s;
                end else begin
                    step_en_s = 1'b1;
                    skip_d    = 1'b0;
                    if (run_n_q) begin
                        budget_d = budget_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d  = (budget_q == {{(CNT_W-1){1'b0}}, 1'b1}) ? ST_IDLE : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired-instruction counter; clear beats a same-cycle increment.
    always_comb begin
        if (dbg.cntClear) begin
            count_d = '0;
        end else begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, step_en_s};
        end
    end

    // Controller state registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            budget_q    <= '0;
            run_n_q     <= 1'b0;
            skip_q      <= 1'b0;
            hit_index_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            budget_q    <= budget_d;
            run_n_q     <= run_n_d;
            skip_q      <= skip_d;
            hit_index_q <= hit_index_d;
            count_q     <= count_d;
        end
    end

    assign dbg.stepEnable = step_en_s;
    assign dbg.running    = (state_q == ST_RUN);
    assign dbg.hitValid   = (state_q == ST_BREAK);
    assign dbg.hitIndex   = hit_index_q;
    assign dbg.instrCount = count_q;

endmodule
